// File: rtl/uart_tx_8n1.sv
// UART transmitter: one start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 27,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = bit_end ? 8'd0 : baud_q + 8'd1;
        end
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    state_d = START;
                    shift_d = data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                // bit_q is reused here to count stop bits
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: two instances (1 and 2 stop bits) checked every
// cycle against a frame-position model of the serial waveform.
module tb_uart_tx_8n1;

    localparam int C = 27;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk_3125;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] data;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // model: per instance, whether a frame is active and cycle position in it
    int         stops [2];
    logic       act [2];
    int         pos [2];
    logic [7:0] md [2];
    logic       done_e [2];

    uart_tx_8n1 #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
        .clk_3125(clk_3125),
        .rst_n(rst_n),
        .tx_start(tx_start),
        .data(data),
        .tx(tx_a),
        .busy(busy_a),
        .tx_done(done_a)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
        .clk_3125(clk_3125),
        .rst_n(rst_n),
        .tx_start(tx_start),
        .data(data),
        .tx(tx_b),
        .busy(busy_b),
        .tx_done(done_b)
    );

    initial clk_3125 = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic int flen(input int i);
        return (9 + P + stops[i]) * C;
    endfunction

    // Line level at a given cycle of a frame carrying d.
    function automatic logic lvl(input int p, input logic [7:0] d);
        int b;
        b = p / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check_outs();
        logic [1:0] t, bz, dn;
        t  = {tx_b, tx_a};
        bz = {busy_b, busy_a};
        dn = {done_b, done_a};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx%0d", i), 32'(t[i]),
                32'(act[i] ? lvl(pos[i], md[i]) : 1'b1));
            chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(act[i]));
            chk($sformatf("done%0d", i), 32'(dn[i]), 32'(done_e[i]));
        end
    endtask

    task automatic tick();
        logic idle;
        @(posedge clk_3125);
        for (int i = 0; i < 2; i++) begin
            done_e[i] = 1'b0;
            if (!rst_n) begin
                act[i] = 1'b0;
                pos[i] = 0;
            end else begin
                idle = !act[i];
                if (act[i]) begin
                    pos[i]++;
                    if (pos[i] == flen(i)) begin
                        act[i] = 1'b0;
                        done_e[i] = 1'b1;
                    end
                end
                if (idle && tx_start) begin
                    act[i] = 1'b1;
                    pos[i] = 0;
                    md[i] = data;
                end
            end
        end
        #1;
        cyc++;
        check_outs();
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) begin
            data = 8'($urandom);
            tick();
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        tx_start = 1'b1;
        data = d;
        tick();
        tx_start = 1'b0;
        data = 8'($urandom);
    endtask

    initial begin
        stops[0] = 1;
        stops[1] = 2;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            pos[i] = 0;
            md[i] = 8'h00;
            done_e[i] = 1'b0;
        end
        rst_n = 1'b0;
        tx_start = 1'b0;
        data = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        idle_n(3);

        // asynchronous reset at cycle 100 of a frame
        pulse(8'h53);
        idle_n(99);
        #50;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            done_e[i] = 1'b0;
        end
        chk("rst_tx_a", 32'(tx_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_tx_b", 32'(tx_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle_n(320);

        // plain frame 'S'
        pulse(8'h53);
        idle_n(330);

        // start request at cycle 50 of a frame is ignored
        pulse(8'h53);
        idle_n(49);
        pulse(8'h4C);
        idle_n(330);

        // back-to-back: request raised in the tx_done cycle
        pulse(8'h53);
        begin
            int k;
            for (k = 0; k < 400 && !done_e[0]; k++) idle_n(1);
            chk("b2b_done_seen", 32'(done_e[0]), 32'd1);
        end
        pulse(8'h2D);
        idle_n(340);

        // 2-stop-bit instance sees '#'
        pulse(8'h23);
        idle_n(340);

        // parity patterns
        pulse(8'h53);
        idle_n(340);
        pulse(8'h4D);
        idle_n(340);
        pulse(8'h49);
        idle_n(340);

        // random traffic, occasionally holding tx_start for several cycles
        for (int f = 0; f < 12; f++) begin
            int hold;
            hold = $urandom_range(1, 4);
            tx_start = 1'b1;
            for (int h = 0; h < hold; h++) begin
                data = 8'($urandom);
                tick();
            end
            tx_start = 1'b0;
            idle_n($urandom_range(0, 320));
        end

        idle_n(340);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial transmitter stage directly downstream of the station-log message sequencer.
- Consumes its one-cycle tx_start strobe and 8-bit character, then serialises the character as an asynchronous UART frame on the tx pin.
- Returns a one-cycle tx_done pulse, which the sequencer uses to advance to the next character.
- Runs entirely in the 3.125 MHz clock domain.

Parameters:
- CLKS_PER_BIT, 27, clk_3125 cycles per UART bit (3.125 MHz / 27 ≈ 115200 baud); legal range 2..255.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_3125  input  1  system clock, 3.125 MHz, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_start  input  1  one-cycle request; data is valid in the same cycle.
- data  input  8  character to send, sampled only when tx_start is accepted.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0x00.
- Reset mid-frame aborts the frame immediately: tx returns high asynchronously and no tx_done is issued.
- All outputs are registered.
- States:
  - IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1, busy=0. On a rising edge with tx_start=1, latch data into the shift register; on that same edge tx goes 0, busy goes 1, baud counter clears, state -> START.
  - START: hold tx=0 for exactly CLKS_PER_BIT cycles, then -> DATA with tx = data[0].
  - DATA: shift LSB first. Each bit is held exactly CLKS_PER_BIT cycles. A 3-bit index counts 0..7; after bit 7 -> PARITY (if enabled) or STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the edge that ends the last stop cycle: tx_done=1 for one cycle, busy=0, state -> IDLE.
- Baud counter: width 8; counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit. No fractional-baud correction.
- Frame length: tx_start edge to tx_done edge = (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
  - Default: 270 cycles.
- tx_start while busy=1: ignored. No queueing; data is not re-sampled and the frame in flight is unaffected.
- tx_start asserted in the same cycle tx_done=1: accepted, because state is already IDLE. This gives back-to-back frames with zero idle gap.
- tx_start held high for several cycles: only the first edge in IDLE is accepted.
  - If it is still high after tx_done, a new frame starts with the current data.
- data changing after acceptance has no effect on the frame in flight.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Bit value is even parity: XOR of the 8 latched data bits.
  - Held CLKS_PER_BIT cycles; frame grows by one bit (default 297 cycles).
- Undefined:
  - PARITY state and its logic are absent.
  - DATA goes directly to STOP; frame is 8N1.

Test Plan:
1. Reset with rst_n=0 mid-frame (cycle 100 of a frame) -> tx=1, busy=0, tx_done=0 within the same cycle. After release, no tx_done appears for the aborted frame.
2. tx_start pulse with data=0x53 ('S'), default params -> tx sequence 0,1,1,0,0,1,0,1,0,1, each level held 27 cycles. busy high 270 cycles. tx_done pulses once, at cycle 270 after acceptance.
3. tx_start pulse with data=0x4C at cycle 50 of an active 0x53 frame -> ignored. The 0x53 frame completes unchanged and no second frame follows.
4. tx_start with data=0x2D asserted in the tx_done cycle of the previous frame -> new start bit begins on that edge, with no idle-high cycle between the frames. Second tx_done follows 270 cycles later.
5. STOP_BITS=2, data=0x23 ('#') -> stop level held 54 cycles. tx_done arrives 297 cycles after acceptance.
6. UART_TX_PARITY_EN defined:
   - data=0x53 (four ones) -> parity bit 0.
   - data=0x4D (four ones) -> parity bit 0.
   - data=0x49 (three ones) -> parity bit 1.
   - In each case tx_done arrives at cycle 297.
